mc_ctrl: RTL and testbench

MC_CTRL -- requirements
Module: mc_ctrl

---
 rtl/mc_ctrl_if.sv | 32 +++
 rtl/mc_ctrl.sv | 146 ++++++++++++++
 tb/tb_mc_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_if.sv
// Handshake/bus bundle between the multi-cycle controller and its datapath/memories.
// The controller takes the master view; the datapath side takes the slave view.
interface mc_ctrl_if #(
   parameter int CNT_W = 32
);
   logic [16:0]      inst;
   logic             imem_ack;
   logic             dmem_ack;
   logic             br_taken;
   logic             imem_req;
   logic             ir_we;
   logic             dmem_req;
   logic             dmem_we;
   logic             rf_we;
   logic             pc_we;
   logic [1:0]       npc_op;
   logic [2:0]       state;
   logic             illegal;
   logic [CNT_W-1:0] instret;

   modport master (
      input  inst, imem_ack, dmem_ack, br_taken,
      output imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we,
             npc_op, state, illegal, instret
   );

   modport slave (
      output inst, imem_ack, dmem_ack, br_taken,
      input  imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we,
             npc_op, state, illegal, instret
   );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle CPU control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with HALT on
// illegal opcodes, plus a wrapping retired-instruction counter.
module mc_ctrl #(
   parameter int CNT_W = 32
) (
   input logic       clk,
   input logic       rst,
   mc_ctrl_if.master bus
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd7
   } state_t;

   typedef enum logic [2:0] {
      C_ALU, C_LOAD, C_STORE, C_UIMM, C_BR, C_B, C_LINK, C_ILL
   } cls_t;

   typedef enum logic [1:0] {
      NPC_PC4 = 2'd0,
      NPC_BRC = 2'd1,
      NPC_JMP = 2'd2
   } npc_t;

   state_t           r_state;
   cls_t             r_cls;
   logic [CNT_W-1:0] r_instret;

   cls_t             w_cls;
   logic             w_imem_req;
   logic             w_ir_we;
   logic             w_dmem_req;
   logic             w_dmem_we;
   logic             w_rf_we;
   logic             w_pc_we;
   npc_t             w_npc;
   logic             w_illegal;

   always_comb begin
      w_cls = C_ILL;
      case (bus.inst[16:11])
         6'b000000:                         w_cls = C_ALU;
         6'b001010:                         w_cls = bus.inst[9] ? C_STORE : C_LOAD;
         6'b000101, 6'b000111:              w_cls = C_UIMM;
         6'b010110, 6'b010111, 6'b011000,
         6'b011010, 6'b011011:              w_cls = C_BR;
         6'b010100:                         w_cls = C_B;
         6'b010011, 6'b010101:              w_cls = C_LINK;
         default:                           w_cls = C_ILL;
      endcase
   end

   // Strobes depend on the same-cycle acks, so they are decoded from the
   // registered state rather than registered themselves; reset masks them all.
   always_comb begin
      w_imem_req = 1'b0;
      w_ir_we    = 1'b0;
      w_dmem_req = 1'b0;
      w_dmem_we  = 1'b0;
      w_rf_we    = 1'b0;
      w_pc_we    = 1'b0;
      w_npc      = NPC_PC4;
      w_illegal  = 1'b0;
      if (!rst) begin
         case (r_state)
            S_FETCH: begin
               w_imem_req = 1'b1;
               w_ir_we    = bus.imem_ack;
            end
            S_EXEC: begin
               if (r_cls == C_B) begin
                  w_pc_we = 1'b1;
                  w_npc   = NPC_JMP;
               end else if (r_cls == C_BR) begin
                  w_pc_we = 1'b1;
                  w_npc   = bus.br_taken ? NPC_BRC : NPC_PC4;
               end
            end
            S_MEM: begin
               w_dmem_req = 1'b1;
               w_dmem_we  = (r_cls == C_STORE);
               w_pc_we    = (r_cls == C_STORE) && bus.dmem_ack;
            end
            S_WB: begin
               w_rf_we = 1'b1;
               w_pc_we = 1'b1;
               w_npc   = (r_cls == C_LINK) ? NPC_JMP : NPC_PC4;
            end
            S_HALT:  w_illegal = 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_FETCH;
         r_cls     <= C_ALU;
         r_instret <= '0;
      end else begin
         if (w_pc_we)
            r_instret <= r_instret + CNT_W'(1);
         case (r_state)
            S_FETCH: begin
               if (bus.imem_ack)
                  r_state <= S_DECODE;
            end
            S_DECODE: begin
               r_cls   <= w_cls;
               r_state <= (w_cls == C_ILL) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
               case (r_cls)
                  C_LOAD, C_STORE: r_state <= S_MEM;
                  C_BR, C_B:       r_state <= S_FETCH;
                  default:         r_state <= S_WB;
               endcase
            end
            S_MEM: begin
               if (bus.dmem_ack)
                  r_state <= (r_cls == C_LOAD) ? S_WB : S_FETCH;
            end
            S_WB:    r_state <= S_FETCH;
            S_HALT:  r_state <= S_HALT;
            default: r_state <= S_FETCH;
         endcase
      end
   end

   assign bus.imem_req = w_imem_req;
   assign bus.ir_we    = w_ir_we;
   assign bus.dmem_req = w_dmem_req;
   assign bus.dmem_we  = w_dmem_we;
   assign bus.rf_we    = w_rf_we;
   assign bus.pc_we    = w_pc_we;
   assign bus.npc_op   = w_npc;
   assign bus.state    = r_state;
   assign bus.illegal  = w_illegal;
   assign bus.instret  = r_instret;

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: two instances (32-bit and 4-bit counters) share stimulus and are
// checked cycle by cycle against traces planned from the instruction-class rules.
module tb_mc_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [16:0] t_inst;
   logic        t_iack;
   logic        t_dack;
   logic        t_brt;

   always #5 clk = ~clk;

   mc_ctrl_if #(.CNT_W(32)) if_a ();
   mc_ctrl_if #(.CNT_W(4))  if_b ();

   assign if_a.inst     = t_inst;
   assign if_a.imem_ack = t_iack;
   assign if_a.dmem_ack = t_dack;
   assign if_a.br_taken = t_brt;
   assign if_b.inst     = t_inst;
   assign if_b.imem_ack = t_iack;
   assign if_b.dmem_ack = t_dack;
   assign if_b.br_taken = t_brt;

   mc_ctrl #(.CNT_W(32)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
   mc_ctrl #(.CNT_W(4))  dut_b (.clk(clk), .rst(rst), .bus(if_b));

   localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_UIMM = 3,
                  K_BR = 4, K_B = 5, K_LINK = 6, K_ILL = 7;

   localparam logic [16:0] I_ADDI = 17'b00000010100000000;
   localparam logic [16:0] I_LDW  = 17'b001010_0_010_0000000;
   localparam logic [16:0] I_STW  = 17'b001010_0_110_0000000;
   localparam logic [16:0] I_BEQ  = 17'b010110_0_000_0000000;
   localparam logic [16:0] I_BAD  = 17'b111111_0_000_0000000;

   typedef struct {
      logic        rst;
      logic [16:0] inst;
      logic        iack;
      logic        dack;
      logic        brt;
      logic [11:0] exp;   // {state, imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, npc_op, illegal}
   } cyc_t;

   cyc_t        trace[$];
   int unsigned n_checks;
   int unsigned n_fail;
   logic [31:0] model_cnt;
   logic [5:0]  legal_ops [13] = '{6'b000000, 6'b001010, 6'b000101, 6'b000111,
                                   6'b010110, 6'b010111, 6'b011000, 6'b011010,
                                   6'b011011, 6'b010100, 6'b010011, 6'b010101,
                                   6'b001010};

   function automatic int classify(input logic [16:0] ins);
      case (ins[16:11])
         6'b000000:                                               return K_ALU;
         6'b001010:                                               return ins[9] ? K_STORE : K_LOAD;
         6'b000101, 6'b000111:                                    return K_UIMM;
         6'b010110, 6'b010111, 6'b011000, 6'b011010, 6'b011011:   return K_BR;
         6'b010100:                                               return K_B;
         6'b010011, 6'b010101:                                    return K_LINK;
         default:                                                 return K_ILL;
      endcase
   endfunction

   function automatic logic [11:0] mk(input logic [2:0] st, input logic [5:0] strobes,
                                      input logic [1:0] npc, input logic ill);
      return {st, strobes, npc, ill};
   endfunction

   function automatic logic rbit();
      return 1'($urandom);
   endfunction

   function automatic logic [16:0] rinst();
      return 17'($urandom);
   endfunction

   function automatic logic [16:0] rlegal();
      int unsigned idx;
      idx = $urandom_range(0, 12);
      return {legal_ops[idx], 11'($urandom)};
   endfunction

   task automatic push(input logic r, input logic [16:0] ins, input logic ia,
                       input logic da, input logic b, input logic [11:0] e);
      cyc_t c;
      c.rst = r; c.inst = ins; c.iack = ia; c.dack = da; c.brt = b; c.exp = e;
      trace.push_back(c);
   endtask

   // Expected cycle-by-cycle behaviour of one instruction; inst is only held stable
   // in DECODE/EXEC and acks outside their request window are random noise.
   task automatic plan_instr(input logic [16:0] ins, input int unsigned iw,
                             input int unsigned dw, input logic brt);
      int         k;
      logic       st;
      logic       pcb;
      logic [1:0] npc;
      k   = classify(ins);
      st  = (k == K_STORE);
      for (int unsigned i = 0; i < iw; i++)
         push(1'b0, rinst(), 1'b0, rbit(), rbit(), mk(3'd0, 6'b100000, 2'd0, 1'b0));
      push(1'b0, rinst(), 1'b1, rbit(), rbit(), mk(3'd0, 6'b110000, 2'd0, 1'b0));
      push(1'b0, ins, rbit(), rbit(), rbit(), mk(3'd1, 6'b000000, 2'd0, 1'b0));
      if (k == K_ILL) return;
      pcb = (k == K_BR) || (k == K_B);
      npc = (k == K_B) ? 2'd2 : ((k == K_BR) && brt) ? 2'd1 : 2'd0;
      push(1'b0, ins, rbit(), rbit(), brt, mk(3'd2, {5'b00000, pcb}, npc, 1'b0));
      if (k == K_LOAD || k == K_STORE) begin
         for (int unsigned i = 0; i < dw; i++)
            push(1'b0, rinst(), rbit(), 1'b0, rbit(), mk(3'd3, {3'b001, st, 2'b00}, 2'd0, 1'b0));
         push(1'b0, rinst(), rbit(), 1'b1, rbit(), mk(3'd3, {3'b001, st, 1'b0, st}, 2'd0, 1'b0));
      end
      if (k == K_ALU || k == K_UIMM || k == K_LINK || k == K_LOAD)
         push(1'b0, rinst(), rbit(), rbit(), rbit(),
              mk(3'd4, 6'b000011, (k == K_LINK) ? 2'd2 : 2'd0, 1'b0));
   endtask

   task automatic apply_cycle(input cyc_t c, output logic [11:0] oa, output logic [11:0] ob,
                              output logic [31:0] ia, output logic [3:0] ib);
      @(negedge clk);
      rst    = c.rst;
      t_inst = c.inst;
      t_iack = c.iack;
      t_dack = c.dack;
      t_brt  = c.brt;
      #1;
      oa = {if_a.state, if_a.imem_req, if_a.ir_we, if_a.dmem_req, if_a.dmem_we,
            if_a.rf_we, if_a.pc_we, if_a.npc_op, if_a.illegal};
      ob = {if_b.state, if_b.imem_req, if_b.ir_we, if_b.dmem_req, if_b.dmem_we,
            if_b.rf_we, if_b.pc_we, if_b.npc_op, if_b.illegal};
      ia = if_a.instret;
      ib = if_b.instret;
   endtask

   task automatic test_reset();
      cyc_t c; logic [11:0] oa, ob; logic [31:0] ia; logic [3:0] ib;
      c.rst = 1'b1; c.inst = rinst(); c.iack = 1'b1; c.dack = 1'b1; c.brt = 1'b1; c.exp = '0;
      apply_cycle(c, oa, ob, ia, ib);
      model_cnt = '0;
      for (int unsigned i = 0; i < 2; i++)
         push(1'b1, rinst(), rbit(), rbit(), rbit(), mk(3'd0, 6'b000000, 2'd0, 1'b0));
      push(1'b0, rinst(), 1'b0, rbit(), rbit(), mk(3'd0, 6'b100000, 2'd0, 1'b0));
      while (trace.size() > 0) begin
         c = trace.pop_front();
         apply_cycle(c, oa, ob, ia, ib);
         n_checks++;
         if ({oa, ob} !== {c.exp, c.exp}) begin
            n_fail++; $display("FAIL reset_outputs t=%0t got=%h/%h want=%h", $time, oa, ob, c.exp);
         end
         n_checks++;
         if ({ia, ib} !== {model_cnt, model_cnt[3:0]}) begin
            n_fail++; $display("FAIL reset_instret t=%0t got=%0d/%0d want=%0d", $time, ia, ib, model_cnt);
         end
         if (c.rst) model_cnt = '0; else if (c.exp[3]) model_cnt++;
      end
   endtask

   task automatic test_addi();
      cyc_t c; logic [11:0] oa, ob; logic [31:0] ia; logic [3:0] ib;
      plan_instr(I_ADDI, 0, 0, rbit());
      while (trace.size() > 0) begin
         c = trace.pop_front();
         apply_cycle(c, oa, ob, ia, ib);
         n_checks++;
         if ({oa, ob} !== {c.exp, c.exp}) begin
            n_fail++; $display("FAIL addi_outputs t=%0t got=%h/%h want=%h", $time, oa, ob, c.exp);
         end
         n_checks++;
         if ({ia, ib} !== {model_cnt, model_cnt[3:0]}) begin
            n_fail++; $display("FAIL addi_instret t=%0t got=%0d/%0d want=%0d", $time, ia, ib, model_cnt);
         end
         if (c.rst) model_cnt = '0; else if (c.exp[3]) model_cnt++;
      end
   endtask

   task automatic test_mem();
      cyc_t c; logic [11:0] oa, ob; logic [31:0] ia; logic [3:0] ib;
      plan_instr(I_LDW, 0, 3, rbit());
      plan_instr(I_STW, 0, 0, rbit());
      plan_instr(I_STW, 2, 1, rbit());
      while (trace.size() > 0) begin
         c = trace.pop_front();
         apply_cycle(c, oa, ob, ia, ib);
         n_checks++;
         if ({oa, ob} !== {c.exp, c.exp}) begin
            n_fail++; $display("FAIL mem_outputs t=%0t got=%h/%h want=%h", $time, oa, ob, c.exp);
         end
         n_checks++;
         if ({ia, ib} !== {model_cnt, model_cnt[3:0]}) begin
            n_fail++; $display("FAIL mem_instret t=%0t got=%0d/%0d want=%0d", $time, ia, ib, model_cnt);
         end
         if (c.rst) model_cnt = '0; else if (c.exp[3]) model_cnt++;
      end
   endtask

   task automatic test_branch();
      cyc_t c; logic [11:0] oa, ob; logic [31:0] ia; logic [3:0] ib;
      plan_instr(I_BEQ, 0, 0, 1'b1);
      plan_instr(I_BEQ, 0, 0, 1'b0);
      plan_instr({6'b010100, 11'($urandom)}, 1, 0, rbit());
      plan_instr({6'b010101, 11'($urandom)}, 0, 0, rbit());
      while (trace.size() > 0) begin
         c = trace.pop_front();
         apply_cycle(c, oa, ob, ia, ib);
         n_checks++;
         if ({oa, ob} !== {c.exp, c.exp}) begin
            n_fail++; $display("FAIL branch_outputs t=%0t got=%h/%h want=%h", $time, oa, ob, c.exp);
         end
         n_checks++;
         if ({ia, ib} !== {model_cnt, model_cnt[3:0]}) begin
            n_fail++; $display("FAIL branch_instret t=%0t got=%0d/%0d want=%0d", $time, ia, ib, model_cnt);
         end
         if (c.rst) model_cnt = '0; else if (c.exp[3]) model_cnt++;
      end
   endtask

   task automatic test_illegal();
      cyc_t c; logic [11:0] oa, ob; logic [31:0] ia; logic [3:0] ib;
      plan_instr(I_BAD, 1, 0, 1'b0);
      for (int unsigned i = 0; i < 6; i++)
         push(1'b0, rinst(), i[0], rbit(), rbit(), mk(3'd7, 6'b000000, 2'd0, 1'b1));
      push(1'b1, rinst(), 1'b1, 1'b1, rbit(), mk(3'd7, 6'b000000, 2'd0, 1'b0));
      plan_instr(I_ADDI, 0, 0, rbit());
      while (trace.size() > 0) begin
         c = trace.pop_front();
         apply_cycle(c, oa, ob, ia, ib);
         n_checks++;
         if ({oa, ob} !== {c.exp, c.exp}) begin
            n_fail++; $display("FAIL illegal_outputs t=%0t got=%h/%h want=%h", $time, oa, ob, c.exp);
         end
         n_checks++;
         if ({ia, ib} !== {model_cnt, model_cnt[3:0]}) begin
            n_fail++; $display("FAIL illegal_instret t=%0t got=%0d/%0d want=%0d", $time, ia, ib, model_cnt);
         end
         if (c.rst) model_cnt = '0; else if (c.exp[3]) model_cnt++;
      end
   endtask

   // 16 retirements wrap the 4-bit counter to 0; then a reset lands mid-MEM with ack high.
   task automatic test_wrap();
      cyc_t c; logic [11:0] oa, ob; logic [31:0] ia; logic [3:0] ib;
      push(1'b1, rinst(), rbit(), rbit(), rbit(), mk(3'd0, 6'b000000, 2'd0, 1'b0));
      for (int unsigned i = 0; i < 16; i++)
         plan_instr(rlegal(), 0, $urandom_range(0, 1), rbit());
      plan_instr(I_LDW, 0, 5, 1'b0);
      while (trace.size() > 5 + 16 * 0 && trace[trace.size()-1].exp[11:9] != 3'd3)
         void'(trace.pop_back());
      while (trace[trace.size()-1].exp[11:9] == 3'd3 && trace[trace.size()-2].exp[11:9] == 3'd3
             && trace[trace.size()-3].exp[11:9] == 3'd3)
         void'(trace.pop_back());
      push(1'b1, rinst(), 1'b1, 1'b1, 1'b0, mk(3'd3, 6'b000000, 2'd0, 1'b0));
      plan_instr(I_BEQ, 0, 0, 1'b1);
      while (trace.size() > 0) begin
         c = trace.pop_front();
         apply_cycle(c, oa, ob, ia, ib);
         n_checks++;
         if ({oa, ob} !== {c.exp, c.exp}) begin
            n_fail++; $display("FAIL wrap_outputs t=%0t got=%h/%h want=%h", $time, oa, ob, c.exp);
         end
         n_checks++;
         if ({ia, ib} !== {model_cnt, model_cnt[3:0]}) begin
            n_fail++; $display("FAIL wrap_instret t=%0t got=%0d/%0d want=%0d", $time, ia, ib, model_cnt);
         end
         if (c.rst) model_cnt = '0; else if (c.exp[3]) model_cnt++;
      end
   endtask

   task automatic test_back_to_back();
      cyc_t c; logic [11:0] oa, ob; logic [31:0] ia; logic [3:0] ib;
      for (int unsigned i = 0; i < 40; i++)
         plan_instr(rlegal(), $urandom_range(0, 3), $urandom_range(0, 3), rbit());
      while (trace.size() > 0) begin
         c = trace.pop_front();
         apply_cycle(c, oa, ob, ia, ib);
         n_checks++;
         if ({oa, ob} !== {c.exp, c.exp}) begin
            n_fail++; $display("FAIL b2b_outputs t=%0t got=%h/%h want=%h", $time, oa, ob, c.exp);
         end
         n_checks++;
         if ({ia, ib} !== {model_cnt, model_cnt[3:0]}) begin
            n_fail++; $display("FAIL b2b_instret t=%0t got=%0d/%0d want=%0d", $time, ia, ib, model_cnt);
         end
         if (c.rst) model_cnt = '0; else if (c.exp[3]) model_cnt++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation exceeded its time limit");
      $fatal(1);
   end

   initial begin
      rst       = 1'b1;
      t_inst    = '0;
      t_iack    = 1'b0;
      t_dack    = 1'b0;
      t_brt     = 1'b0;
      n_checks  = 0;
      n_fail    = 0;
      model_cnt = '0;
      test_reset();
      test_addi();
      test_mem();
      test_branch();
      test_illegal();
      test_wrap();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
